// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame state encoding, default line timing and
// the bit-period arithmetic used by both the transmit and receive paths.
package uart_tx_pkg;

    localparam int DEFAULT_CLK_FREQ  = 50_000_000;
    localparam int DEFAULT_BAUD_RATE = 115_200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // A one-clock bit period still needs a one-bit counter.
    function automatic int ctr_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1 and flags the last cycle of
// each bit. Held at zero while restart is high so a frame starts aligned.
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CTR_W = ctr_width(CLKS_PER_BIT);
    localparam logic [CTR_W-1:0] LAST = CTR_W'(CLKS_PER_BIT - 1);

    logic [CTR_W-1:0] bit_ctr;

    assign tick = (bit_ctr == LAST);

    // NOTE: reset is synchronous, so it lives inside the clocked branch and only
    // takes effect at a posedge; state updates use <= so every register sees
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst || restart || tick) begin
            bit_ctr <= '0;
        end else begin
            bit_ctr <= bit_ctr + CTR_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter (8N1/8E1/8O1, 1 or 2 stop bits): one byte per valid/ready
// handshake, serialised LSB-first on a registered, idle-high serial_out.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       serial_out
);

    localparam int   CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic ODD_BIT      = (PARITY_ODD != 0);

    tx_state_t  state;
    logic [7:0] shift;
    logic [2:0] bit_idx;
    logic       stop_idx;
    logic       parity_bit;
    logic       tick;
    logic       last_stop;
    logic       accept;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .restart(state == IDLE),
        .tick   (tick)
    );

    assign last_stop = (int'(stop_idx) == STOP_BITS - 1);
    // Ready also opens on the final stop cycle so frames can run back-to-back.
    assign tx_ready  = rst && ((state == IDLE) || (state == STOP && last_stop && tick));
    assign accept    = tx_valid && tx_ready;
    assign tx_busy   = (state != IDLE);

    // serial_out is driven from the current state, so the line trails the
    // state by one cycle while every bit still lasts CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            tx_done    <= 1'b0;
            shift      <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    if (accept) begin
                        shift      <= tx_data;
                        parity_bit <= (^tx_data) ^ ODD_BIT;
                        state      <= START;
                    end
                end
                START: begin
                    serial_out <= 1'b0;
                    if (tick) begin
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    serial_out <= shift[0];
                    if (tick) begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            stop_idx <= 1'b0;
                            state    <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    serial_out <= parity_bit;
                    if (tick) begin
                        stop_idx <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    serial_out <= 1'b1;
                    if (tick) begin
                        if (last_stop) begin
                            tx_done <= 1'b1;
                            if (accept) begin
                                shift      <= tx_data;
                                parity_bit <= (^tx_data) ^ ODD_BIT;
                                state      <= START;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: three configurations (8N1, 8E2, 8O1) at
// ten clocks per bit, checked cycle by cycle against a frame-level model.
module tb_uart_tx;

    localparam int C = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] tx_valid;
    logic [2:0] tx_ready;
    logic [2:0] tx_busy;
    logic [2:0] tx_done;
    logic [2:0] serial_out;
    logic [7:0] tx_data [3];

    int errors = 0;
    int checks = 0;

    int pen_cfg  [3] = '{0, 1, 1};
    int odd_cfg  [3] = '{0, 0, 1};
    int stop_cfg [3] = '{1, 2, 1};

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) d0 (
        .clk(clk), .rst(rst), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
        .tx_busy(tx_busy[0]), .tx_done(tx_done[0]), .serial_out(serial_out[0]));

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) d1 (
        .clk(clk), .rst(rst), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
        .tx_busy(tx_busy[1]), .tx_done(tx_done[1]), .serial_out(serial_out[1]));

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) d2 (
        .clk(clk), .rst(rst), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
        .tx_busy(tx_busy[2]), .tx_done(tx_done[2]), .serial_out(serial_out[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level k cycles into a frame: start, D0..D7, optional parity, stop(s).
    function automatic logic exp_line(input logic [7:0] d, input int pen, input int odd, input int k);
        int b;
        b = k / C;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (pen != 0 && b == 9) return (^d) ^ (odd != 0);
        return 1'b1;
    endfunction

    task automatic wait_ready(input int u);
        int n;
        n = 0;
        while (tx_ready[u] !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("ready_wait u%0d", u), tx_ready[u], 1);
    endtask

    task automatic tx_frame(input int u, input logic [7:0] d, input bit scramble);
        int flen;
        int done_at;
        int done_cnt;
        flen     = (9 + pen_cfg[u] + stop_cfg[u]) * C;
        done_at  = -1;
        done_cnt = 0;
        wait_ready(u);
        tx_data[u]  = d;
        tx_valid[u] = 1'b1;
        @(negedge clk);
        tx_valid[u] = 1'b0;
        if (scramble) tx_data[u] = 8'hFF;
        check($sformatf("busy_accept u%0d", u), tx_busy[u], 1);
        check($sformatf("ready_accept u%0d", u), tx_ready[u], 0);
        check($sformatf("line_accept u%0d", u), serial_out[u], 1);
        for (int j = 1; j <= flen; j++) begin
            @(negedge clk);
            check($sformatf("line u%0d d%02h j%0d", u, d, j), serial_out[u],
                  exp_line(d, pen_cfg[u], odd_cfg[u], j - 1));
            if (tx_done[u] === 1'b1) begin
                done_cnt++;
                done_at = j;
            end
        end
        check($sformatf("done_count u%0d", u), done_cnt, 1);
        check($sformatf("done_cycle u%0d", u), done_at, flen);
        @(negedge clk);
        check($sformatf("done_clear u%0d", u), tx_done[u], 0);
        check($sformatf("busy_end u%0d", u), tx_busy[u], 0);
        check($sformatf("line_end u%0d", u), serial_out[u], 1);
        check($sformatf("ready_end u%0d", u), tx_ready[u], 1);
    endtask

    initial begin
        int done_t [2];
        int nd;
        logic [7:0] d;

        rst      = 1'b0;
        tx_valid = '0;
        for (int u = 0; u < 3; u++) tx_data[u] = 8'h00;

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_line u%0d", u), serial_out[u], 1);
            check($sformatf("rst_ready u%0d", u), tx_ready[u], 0);
            check($sformatf("rst_busy u%0d", u), tx_busy[u], 0);
            check($sformatf("rst_done u%0d", u), tx_done[u], 0);
        end
        rst = 1'b1;
        @(negedge clk);
        check("release_ready", tx_ready[0], 1);

        // Directed frames: 8N1 0xA5, 0x07 with even/2-stop and odd parity.
        tx_frame(0, 8'hA5, 1'b0);
        tx_frame(1, 8'h07, 1'b0);
        tx_frame(2, 8'h07, 1'b0);

        // Data changed right after accept must not leak into the frame.
        tx_frame(0, 8'h00, 1'b1);

        // Back-to-back 0x55 then 0x0F with valid held through the handoff.
        wait_ready(0);
        tx_data[0]  = 8'h55;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_data[0] = 8'h0F;
        nd = 0;
        done_t = '{-1, -1};
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            check($sformatf("b2b_line j%0d", j), serial_out[0],
                  (j <= 100) ? exp_line(8'h55, 0, 0, j - 1) : exp_line(8'h0F, 0, 0, j - 101));
            if (tx_done[0] === 1'b1) begin
                if (nd < 2) done_t[nd] = j;
                nd++;
            end
            if (j == 99) check("b2b_ready_handoff", tx_ready[0], 1);
            if (j == 100) begin
                check("b2b_busy_handoff", tx_busy[0], 1);
                tx_valid[0] = 1'b0;
            end
        end
        check("b2b_done_count", nd, 2);
        check("b2b_done_first", done_t[0], 100);
        check("b2b_done_second", done_t[1], 200);
        @(negedge clk);
        check("b2b_idle_busy", tx_busy[0], 0);

        // Reset asserted during data bit 3.
        wait_ready(0);
        tx_data[0]  = 8'hC3;
        tx_valid[0] = 1'b1;
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (45) @(negedge clk);
        check("midrst_d3_line", serial_out[0], exp_line(8'hC3, 0, 0, 44));
        rst = 1'b0;
        @(negedge clk);
        check("midrst_line", serial_out[0], 1);
        check("midrst_busy", tx_busy[0], 0);
        check("midrst_ready", tx_ready[0], 0);
        nd = 0;
        for (int j = 0; j < 3; j++) begin
            if (tx_done[0] === 1'b1) nd++;
            if (j < 2) @(negedge clk);
        end
        rst = 1'b1;
        for (int j = 0; j < 2 * C; j++) begin
            @(negedge clk);
            if (tx_done[0] === 1'b1) nd++;
        end
        check("midrst_no_done", nd, 0);
        check("midrst_line_idle", serial_out[0], 1);
        tx_frame(0, 8'h3C, 1'b0);

        // Random bytes across all configurations.
        for (int i = 0; i < 9; i++) begin
            d = 8'($urandom);
            tx_frame(i % 3, d, (i % 4) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
